// File: rtl/vec_ram_mp.sv
// Multi-read, single-write vector RAM: per-lane write strobes, hardware self-clear, write-first forwarding.
// Latency: 1 cycle read (2 with VEC_RAM_OUT_REG_EN); self-clear takes SIZE cycles after reset or clr.
// Backpressure: none; user ren/wen/clr are dropped while busy, and ren/wen are dropped in a clr cycle.
module vec_ram_mp #(
  parameter int SIZE   = 2048,
  parameter int SIZE_L = $clog2(SIZE),
  parameter int LANES  = 16,
  parameter int LANE_W = 32,
  parameter int NUM_RD = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  output logic                             busy,
  input  logic [NUM_RD-1:0]                ren,
  input  logic [NUM_RD*SIZE_L-1:0]         raddr,
  output logic [NUM_RD*LANES*LANE_W-1:0]   rdata,
  output logic [NUM_RD-1:0]                rvalid,
  input  logic                             wen,
  input  logic [SIZE_L-1:0]                waddr,
  input  logic [LANES*LANE_W-1:0]          wdata,
  input  logic [LANES-1:0]                 wstrb
);

  localparam int VW = LANES * LANE_W;
  localparam logic [SIZE_L:0]   SIZE_V = (SIZE_L+1)'(SIZE);
  localparam logic [SIZE_L-1:0] LAST   = SIZE_L'(SIZE - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                   state_q, state_d;
  logic [SIZE_L-1:0]        cnt_q, cnt_d;
  logic                     accept;
  logic                     wr_ok;
  logic [NUM_RD-1:0]        rd_ok, rd_in;

  logic [VW-1:0]            mem [SIZE];
  logic [VW-1:0]            arr_q [NUM_RD];
  logic [NUM_RD-1:0]        ren_q, hit_q, oob_q;
  logic [VW-1:0]            wdat_q;
  logic [LANES-1:0]         wstrb_q;
  logic [NUM_RD-1:0][VW-1:0] hold_q, merged, rd_int;
  logic [NUM_RD*VW-1:0]     rd_flat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = (state_q == CLEAR);
    accept  = (state_q == READY) && !clr;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    wr_ok = accept && wen && ({1'b0, waddr} < SIZE_V);
    rd_ok = '0;
    rd_in = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_in[p] = ({1'b0, raddr[p*SIZE_L +: SIZE_L]} < SIZE_V);
      rd_ok[p] = accept && ren[p];
    end
  end

  // Array port: no reset so the storage and its read registers map onto block RAM.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int l = 0; l < LANES; l++) begin
        if (wstrb[l]) mem[waddr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_ok[p] && rd_in[p]) arr_q[p] <= mem[raddr[p*SIZE_L +: SIZE_L]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ren_q   <= '0;
      hit_q   <= '0;
      oob_q   <= '0;
      wdat_q  <= '0;
      wstrb_q <= '0;
      hold_q  <= '0;
    end else begin
      ren_q <= rd_ok;
      for (int p = 0; p < NUM_RD; p++) begin
        hit_q[p] <= wr_ok && (raddr[p*SIZE_L +: SIZE_L] == waddr);
        oob_q[p] <= !rd_in[p];
      end
      if (wr_ok) begin
        wdat_q  <= wdata;
        wstrb_q <= wstrb;
      end
      // Held output is zeroed on entering and during clear so stale vectors never leak out.
      for (int p = 0; p < NUM_RD; p++) begin
        if (!accept && (state_q == CLEAR || clr)) hold_q[p] <= '0;
        else if (ren_q[p])                        hold_q[p] <= merged[p];
      end
    end
  end

  always_comb begin
    merged  = '0;
    rd_int  = '0;
    rd_flat = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int l = 0; l < LANES; l++) begin
        merged[p][l*LANE_W +: LANE_W] = (hit_q[p] && wstrb_q[l]) ? wdat_q[l*LANE_W +: LANE_W]
                                                                  : arr_q[p][l*LANE_W +: LANE_W];
      end
      if (oob_q[p]) merged[p] = '0;
      rd_int[p] = ren_q[p] ? merged[p] : hold_q[p];
      rd_flat[p*VW +: VW] = rd_int[p];
    end
  end

`ifdef VEC_RAM_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= '0;
    end else begin
      rdata  <= rd_flat;
      rvalid <= ren_q;
    end
  end
`else
  always_comb begin
    rdata  = rd_flat;
    rvalid = ren_q;
  end
`endif

endmodule

// File: tb/tb_vec_ram_mp.sv
// Scoreboard bench for vec_ram_mp (SIZE=16, 3 read ports): driver pushes model results, monitor pops on each cycle.
module tb_vec_ram_mp;

  localparam int SZ = 16;
  localparam int SL = 4;
  localparam int LN = 16;
  localparam int LW = 32;
  localparam int NR = 3;
  localparam int VW = LN * LW;
`ifdef VEC_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic              busy;
  logic [NR-1:0]     ren = '0;
  logic [NR*SL-1:0]  raddr = '0;
  logic [NR*VW-1:0]  rdata;
  logic [NR-1:0]     rvalid;
  logic              wen = 1'b0;
  logic [SL-1:0]     waddr = '0;
  logic [VW-1:0]     wdata = '0;
  logic [LN-1:0]     wstrb = '0;

  vec_ram_mp #(.SIZE(SZ), .LANES(LN), .LANE_W(LW), .NUM_RD(NR)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
    .ren(ren), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [VW-1:0] data;
    bit            clr;
  } exp_t;

  exp_t          q [NR][$];
  logic [VW-1:0] last [NR];
  logic [VW-1:0] mdl [SZ];
  int            cyc = 0;
  int            clr_cnt = SZ;
  bit            busy_exp = 1'b1;
  int            errors = 0;
  int            checks = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int idx, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc=%0d: got %h required %h", nm, idx, cyc, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] merge(input logic [VW-1:0] old, input logic [VW-1:0] nw,
                                          input logic [LN-1:0] strb);
    logic [VW-1:0] r;
    r = old;
    for (int l = 0; l < LN; l++)
      if (strb[l]) r[l*LW +: LW] = nw[l*LW +: LW];
    return r;
  endfunction

  // Monitor: every cycle each port must show exactly what the scoreboard predicts.
  exp_t me;
  bit   ev;
  always @(negedge clk) begin
    check("busy", 0, VW'(busy), VW'(busy_exp));
    for (int p = 0; p < NR; p++) begin
      ev = 1'b0;
      while (q[p].size() > 0 && q[p][0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_read[%0d] cyc=%0d: due at cycle %0d", p, cyc, q[p][0].cyc);
        void'(q[p].pop_front());
      end
      if (q[p].size() > 0 && q[p][0].cyc == cyc) begin
        me = q[p].pop_front();
        if (me.clr) last[p] = '0;
        else begin
          ev      = 1'b1;
          last[p] = me.data;
        end
      end
      check("rvalid", p, VW'(rvalid[p]), VW'(ev));
      check("rdata", p, rdata[p*VW +: VW], last[p]);
    end
  end

  task automatic cycle(input logic [NR-1:0] r_en, input logic [NR*SL-1:0] r_addr, input logic w_en,
                       input logic [SL-1:0] w_addr, input logic [VW-1:0] w_data,
                       input logic [LN-1:0] w_strb, input logic c);
    exp_t          e;
    logic [SL-1:0] a;
    ren = r_en; raddr = r_addr; wen = w_en; waddr = w_addr; wdata = w_data; wstrb = w_strb; clr = c;
    busy_exp = !rst_n || (clr_cnt > 0);
    if (rst_n) begin
      if (clr_cnt > 0) begin
        clr_cnt--;
      end else if (c) begin
        for (int p = 0; p < NR; p++) begin
          e = '{cyc: cyc + LAT, data: '0, clr: 1'b1};
          q[p].push_back(e);
        end
        for (int i = 0; i < SZ; i++) mdl[i] = '0;
        clr_cnt = SZ;
      end else begin
        for (int p = 0; p < NR; p++) begin
          if (r_en[p]) begin
            a = r_addr[p*SL +: SL];
            e = '{cyc: cyc + LAT, data: mdl[a], clr: 1'b0};
            if (w_en && w_addr == a) e.data = merge(mdl[a], w_data, w_strb);
            q[p].push_back(e);
          end
        end
        if (w_en) mdl[w_addr] = merge(mdl[w_addr], w_data, w_strb);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle('0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int l = 0; l < LN; l++) v[l*LW +: LW] = $urandom;
    return v;
  endfunction

  task automatic junk();
    cycle(NR'($urandom), (NR*SL)'($urandom), 1'($urandom), SL'($urandom), rnd_vec(), LN'($urandom),
          1'($urandom));
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    for (int p = 0; p < NR; p++) begin
      q[p].delete();
      last[p] = '0;
    end
    for (int i = 0; i < SZ; i++) mdl[i] = '0;
    clr_cnt = SZ;
    busy_exp = 1'b1;
    ren = '0; wen = 1'b0; clr = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [NR*SL-1:0] addrs(input int a0, input int a1, input int a2);
    logic [NR*SL-1:0] r;
    r = {SL'(a2), SL'(a1), SL'(a0)};
    return r;
  endfunction

  logic [VW-1:0] v;

  initial begin
    for (int p = 0; p < NR; p++) last[p] = '0;
    do_reset(3);
    repeat (SZ) junk();
    // Every entry reads back zero after the self-clear.
    for (int a = 0; a < SZ; a++)
      cycle(3'b111, addrs(a, (a + 5) % SZ, (a + 11) % SZ), 1'b0, '0, '0, '0, 1'b0);

    // Full write then a single-lane overwrite of the same entry.
    for (int l = 0; l < LN; l++) v[l*LW +: LW] = LW'(l);
    cycle('0, '0, 1'b1, SL'(5), v, '1, 1'b0);
    cycle('0, '0, 1'b1, SL'(5), '1, 16'h0001, 1'b0);
    cycle(3'b010, addrs(0, 5, 0), 1'b0, '0, '0, '0, 1'b0);

    // Same-cycle read of a partially strobed write.
    v = {LN{32'hA5A5A5A5}};
    cycle(3'b001, addrs(7, 0, 0), 1'b1, SL'(7), v, 16'h00F0, 1'b0);
    idle();

    // All ports on one address, then a single port.
    v = {LN{32'h00001234}};
    cycle('0, '0, 1'b1, SL'(9), v, '1, 1'b0);
    cycle(3'b111, addrs(9, 9, 9), 1'b0, '0, '0, '0, 1'b0);
    cycle(3'b010, addrs(9, 9, 9), 1'b0, '0, '0, '0, 1'b0);
    idle();

    // clr drops a simultaneous write and wipes the array.
    cycle('0, '0, 1'b1, SL'(2), rnd_vec(), '1, 1'b0);
    cycle(3'b111, addrs(2, 2, 2), 1'b1, SL'(2), rnd_vec(), '1, 1'b1);
    repeat (SZ) junk();
    cycle(3'b111, addrs(2, 9, 5), 1'b0, '0, '0, '0, 1'b0);
    idle();

    // Asynchronous reset while a read result is on the outputs.
    cycle(3'b111, addrs(3, 4, 5), 1'b0, '0, '0, '0, 1'b0);
    repeat (LAT - 1) idle();
    #2;
    check("rvalid_before_rst", 0, VW'(rvalid), VW'(3'b111));
    do_reset(0);
    #1;
    check("rvalid_async_rst", 0, VW'(rvalid), '0);
    check("rdata_async_rst", 0, rdata[VW-1:0], '0);
    check("busy_async_rst", 0, VW'(busy), VW'(1'b1));
    do_reset(2);

    // Reset again part-way through the clear; the clear must restart in full.
    repeat (6) idle();
    #2;
    do_reset(0);
    #1;
    check("busy_midclear_rst", 0, VW'(busy), VW'(1'b1));
    check("rvalid_midclear_rst", 0, VW'(rvalid), '0);
    do_reset(2);
    repeat (SZ) junk();
    cycle(3'b111, addrs(0, 6, 15), 1'b0, '0, '0, '0, 1'b0);

    // Random traffic with address collisions and occasional clr.
    for (int i = 0; i < 400; i++) begin
      logic [SL-1:0]    wa;
      logic [NR*SL-1:0] ra;
      wa = SL'($urandom_range(0, 5));
      for (int p = 0; p < NR; p++)
        ra[p*SL +: SL] = ($urandom_range(0, 2) == 0) ? wa : SL'($urandom_range(0, SZ - 1));
      cycle(NR'($urandom), ra, 1'($urandom), wa, rnd_vec(), LN'($urandom),
            ($urandom_range(0, 63) == 0));
    end

    repeat (SZ + 4) idle();
    for (int p = 0; p < NR; p++) begin
      checks++;
      if (q[p].size() != 0) begin
        errors++;
        $display("FAIL drain[%0d]: got %0d pending required 0", p, q[p].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_ram_mp.md
Name: vec_ram_mp

Overview:
- Parametrised multi-read-port, single-write-port vector block RAM with per-lane write strobes; successor to the 2-read vector RAM used for vector register/scratch storage.
- Generalises lane count, lane width, depth and read-port count.
- Adds reset, hardware self-clear, read-valid tracking and same-address write-to-read forwarding.
- Sits between the vector issue stage (reads) and writeback (strobed writes).

Parameters:
- SIZE, 2048, number of vector entries.
- SIZE_L, $clog2(SIZE), address width (derived; do not override).
- LANES, 16, lanes per vector.
- LANE_W, 32, bits per lane.
- NUM_RD, 2, read ports (1..4).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  pulse; restarts the self-clear sequence (ignored while busy).
- busy  out  1  high while self-clear runs.
- ren  in  NUM_RD  per-port read enable.
- raddr  in  NUM_RD*SIZE_L  port p address at [p*SIZE_L +: SIZE_L].
- rdata  out  NUM_RD*LANES*LANE_W  port p vector; lane l at [(p*LANES+l)*LANE_W +: LANE_W].
- rvalid  out  NUM_RD  per-port data valid.
- wen  in  1  write enable.
- waddr  in  SIZE_L  write address.
- wdata  in  LANES*LANE_W  write vector.
- wstrb  in  LANES  per-lane write mask.

Behaviour:
- State machine: CLEAR and READY.
- Reset:
  - rst_n low forces state CLEAR, clear counter 0, busy=1, rdata=0, rvalid=0, regardless of activity in flight.
  - Array contents are not reset directly; the clear sequence zeroes them.
- CLEAR:
  - Each cycle writes all-zero, all lanes, at address cnt; cnt increments.
  - When cnt==SIZE-1 is written: go to READY and drop busy the next cycle. Total SIZE cycles.
  - User wen, ren and clr are ignored; rvalid=0; rdata holds 0.
- READY:
  - clr=1 returns to CLEAR with cnt=0 and busy=1 next cycle.
  - A wen or ren in the same cycle as clr is dropped.
- Write, READY with wen=1:
  - Lane l of entry waddr updates from wdata lane l only if wstrb[l]=1; other lanes keep their value.
  - wstrb=0 is a no-op.
- Read:
  - Latency 1. ren[p]=1 in cycle N gives rdata port p and rvalid[p]=1 in N+1.
  - ren[p]=0: rvalid[p]=0 next cycle; rdata port p holds its previous value.
- Read-during-write, same cycle, raddr[p]==waddr, wen=1:
  - Per lane: strobed lanes return the new wdata; unstrobed lanes return the stored old value.
  - No stale data is ever returned (write-first, lane-merged).
- Multiple ports reading the same address are legal and return identical data.
- Out-of-range address (SIZE not a power of 2, addr>=SIZE): write is dropped, read returns 0 with rvalid=1.
- Storage is inferred as block RAM. Forwarding is built from a registered compare plus a registered copy of wdata/wstrb, so the array read stays synchronous.

Optional Feature:
- Macro: VEC_RAM_OUT_REG_EN.
- Defined:
  - Adds an output pipeline register on rdata and rvalid; read latency becomes 2.
  - Forwarding still covers a write in the same cycle as the read.
  - A write in the cycle after the read is NOT forwarded.
  - The output register resets to 0.
- Undefined: latency 1 as above.

Test Plan:
- Reset then idle, SIZE=16 -> busy=1 for exactly 16 cycles after rst_n rises, then 0. Reads of addr 0..15 return all zeros, rvalid=1 one cycle after ren.
- Write addr 5, wdata lanes = lane index, wstrb=all-ones; next cycle write addr 5, wdata all 0xFFFFFFFF, wstrb=0x0001; then read port 1 addr 5 -> lane0=0xFFFFFFFF, lanes1..15 = 1..15.
- Same cycle: wen addr 7 with wstrb=0x00F0, data 0xA5A5A5A5; ren port 0 addr 7 (old contents 0) -> next cycle lanes 4..7 = 0xA5A5A5A5, other lanes 0.
- NUM_RD=3: all ports read addr 9 holding 0x1234 in every lane -> all three rdata equal, rvalid=3'b111. ren=3'b010 -> rvalid=3'b010.
- clr pulse in READY with wen asserted to addr 2 -> write dropped, busy high SIZE cycles, afterwards addr 2 reads 0.
- Assert rst_n low mid-CLEAR (cnt=6) and mid-read -> rvalid and rdata 0 immediately (async). After release, the clear restarts from 0 and lasts the full SIZE cycles.
